sort_net_pipe: RTL and testbench
================================

# sort_net_pipe

Parametrised, fully pipelined odd-even transposition sorting network with valid/ready flow control. Accepts one vector of N unsigned elements per cycle and emits its median, minimum and maximum N cycles later, optionally with the full sorted vector. It is the next generation of the fixed 9-input, 8-bit median pipe and serves as the rank-filter core for windowed image and sensor datapaths.

## Interface
- WIDTH, 8, element width in bits (1..32), unsigned
- N, 9, element count; odd, 3..15 (elaboration error otherwise)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input vector present
- in_ready  out  1  pipeline can advance this cycle
- x_flat  in  N*WIDTH  element i at [i*WIDTH +: WIDTH]
- out_valid  out  1  output holds a sorted result
- out_ready  in  1  downstream accepts the result
- median  out  WIDTH  element of rank (N-1)/2 (0 = smallest)
- min_val  out  WIDTH  rank 0
- max_val  out  WIDTH  rank N-1
- out_count  out  16  number of results delivered (out_valid && out_ready), wraps 0xFFFF->0
- sorted_flat  out  N*WIDTH  ascending, rank i at [i*WIDTH +: WIDTH]; present only with SORT_FULL_OUT_EN

## Operation
- N registered stages s0..s(N-1), each with a data register (N*WIDTH) and a valid bit.
- Stage r applies compare-exchange to pairs (i,i+1) with i%2 == r%2, i+1 < N; stage 0 operates on x_flat, stage r>0 on stage r-1's register. Lower index receives the smaller value; equal values pass unchanged.
- advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid/out_ready only, never from in_valid).
- On advance: every stage loads from its predecessor; s0 valid loads in_valid && in_ready. Without advance: all stages hold (global stall); bubbles are not collapsed.
- Data registers load on advance regardless of valid bit; contents with valid = 0 are don't-care but deterministic.
- out_valid = valid of s(N-1); median/min_val/max_val are direct slices of s(N-1), no extra logic after the register.
- out_count increments on every cycle with out_valid && out_ready.

## Timing
- Reset (async assert, sync deassertion handled upstream): all valid bits 0, all data registers 0, out_count 0; thus out_valid=0, median=min_val=max_val=0, sorted_flat=0, in_ready=1.
- Latency: vector accepted in cycle c appears at output in cycle c+N when no stall occurs; each stall cycle adds one.
- Throughput: one vector per cycle while out_ready=1.
- out_valid && !out_ready: output and all stages hold, in_ready=0 same cycle; inputs ignored.
- out_ready while out_valid=0: pipeline advances, nothing counted.
- Reset mid-flight: all in-flight vectors discarded, out_count cleared, no partial output emitted.
- Simultaneous accept and deliver in one cycle: both occur; count increments once.

## Configuration
- SORT_FULL_OUT_EN defined: sorted_flat port exists and carries the full ascending vector of s(N-1).
- Undefined: sorted_flat port absent; median/min_val/max_val unchanged; synthesis must prune nothing else (all stages still required).

## Test plan
- WIDTH=8, N=9, x={9,8,7,6,5,4,3,2,1} in cycle 1, out_ready=1 -> cycle 10 out_valid=1, median=5, min_val=1, max_val=9, out_count=1 next cycle.
- Back-to-back {9..1} then {19,18,17,16,11,12,13,14,15} -> consecutive outputs median 5 then 15, min 11, max 19 in the following cycle.
- Stream 20 random vectors, out_ready low for 3 cycles mid-stream -> in_ready low those cycles, no result lost or duplicated, results match reference model, out_count=20.
- All elements 255 and all 0 alternating -> median 255 then 0; duplicates handled; sorted_flat all-equal with SORT_FULL_OUT_EN.
- Assert rst with 4 vectors in flight -> outputs 0, out_valid 0, out_count 0 immediately; next accepted vector appears exactly N cycles later.
- N=3, WIDTH=16, x={0xFFFF,0x0001,0x8000} -> median 0x8000 at cycle c+3, min 0x0001, max 0xFFFF.

Source files
------------

// File: rtl/sort_net_pipe.sv
// Fully pipelined odd-even transposition sorting network with valid/ready flow control.
// Optional macro SORT_FULL_OUT_EN adds the sorted_flat port carrying the whole ascending vector.
module sort_net_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 9
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] x_flat,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   median,
   output logic [WIDTH-1:0]   min_val,
   output logic [WIDTH-1:0]   max_val,
   output logic [15:0]        out_count
`ifdef SORT_FULL_OUT_EN
   ,
   output logic [N*WIDTH-1:0] sorted_flat
`endif
);

   if ((N % 2) == 0 || N < 3 || N > 15 || WIDTH < 1 || WIDTH > 32) begin : g_bad_param
      $error("sort_net_pipe: N must be odd in 3..15 and WIDTH in 1..32");
   end

   localparam int unsigned MED_IDX = (N - 1) / 2;

   // One odd-even transposition step; the lower index keeps the smaller value.
   function automatic logic [N*WIDTH-1:0] cx_stage(input logic [N*WIDTH-1:0] v,
                                                   input int unsigned      parity);
      logic [N*WIDTH-1:0] r;
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      r = v;
      for (int unsigned i = 0; i + 1 < N; i++) begin
         if ((i % 2) == parity) begin
            a = v[i*WIDTH +: WIDTH];
            b = v[(i+1)*WIDTH +: WIDTH];
            if (a > b) begin
               r[i*WIDTH +: WIDTH]     = b;
               r[(i+1)*WIDTH +: WIDTH] = a;
            end
         end
      end
      return r;
   endfunction

   logic [N*WIDTH-1:0] data_q [N];
   logic [N*WIDTH-1:0] data_d [N];
   logic [N-1:0]       valid_q;
   logic [N-1:0]       valid_d;
   logic [15:0]        out_count_q;
   logic [15:0]        out_count_d;
   logic               advance;
   logic               deliver;

   assign out_valid = valid_q[N-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;
   assign deliver   = out_valid && out_ready;

   // NOTE: always_comb uses blocking assignments and gives every target a value on
   // every path, so no latch is inferred.
   always_comb begin
      data_d[0]   = cx_stage(x_flat, 0);
      valid_d[0]  = in_valid && in_ready;
      for (int unsigned r = 1; r < N; r++) begin
         data_d[r]  = cx_stage(data_q[r-1], r % 2);
         valid_d[r] = valid_q[r-1];
      end
      out_count_d = deliver ? out_count_q + 16'd1 : out_count_q;
   end

   // NOTE: data registers are reset too, so that outputs read zero after reset rather
   // than whatever a discarded vector left behind; non-blocking assignments throughout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < N; r++) data_q[r] <= '0;
         valid_q     <= '0;
         out_count_q <= '0;
      end else begin
         if (advance) begin
            for (int unsigned r = 0; r < N; r++) data_q[r] <= data_d[r];
            valid_q <= valid_d;
         end
         out_count_q <= out_count_d;
      end
   end

   assign median    = data_q[N-1][MED_IDX*WIDTH +: WIDTH];
   assign min_val   = data_q[N-1][0 +: WIDTH];
   assign max_val   = data_q[N-1][(N-1)*WIDTH +: WIDTH];
   assign out_count = out_count_q;
`ifdef SORT_FULL_OUT_EN
   assign sorted_flat = data_q[N-1];
`endif

endmodule

// File: tb/tb_sort_net_pipe.sv
// Scoreboard bench for sort_net_pipe: N=9/WIDTH=8 main instance plus an N=3/WIDTH=16 instance.
// Built with SORT_FULL_OUT_EN undefined.
module tb_sort_net_pipe;

   localparam int N = 9;
   typedef logic [7:0] vec_t [9];
   typedef struct {
      logic [7:0] med;
      logic [7:0] mn;
      logic [7:0] mx;
      int         cyc;
      logic       chk_lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [71:0] x_flat = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  median, min_val, max_val;
   logic [15:0] out_count;

   logic        in_valid3 = 1'b0;
   logic        in_ready3;
   logic [47:0] x_flat3 = '0;
   logic        out_valid3;
   logic [15:0] median3, min3, max3, out_count3;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   deliv = 0;
   int   stall_seen = 0;

   sort_net_pipe #(.WIDTH(8), .N(9)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_flat(x_flat),
      .out_valid(out_valid), .out_ready(out_ready), .median(median), .min_val(min_val),
      .max_val(max_val), .out_count(out_count)
   );

   sort_net_pipe #(.WIDTH(16), .N(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .x_flat(x_flat3),
      .out_valid(out_valid3), .out_ready(1'b1), .median(median3), .min_val(min3),
      .max_val(max3), .out_count(out_count3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
   endtask

   function automatic logic [71:0] pack(input vec_t v);
      logic [71:0] p;
      for (int i = 0; i < 9; i++) p[i*8 +: 8] = v[i];
      return p;
   endfunction

   function automatic vec_t model_sort(input vec_t v);
      vec_t s;
      logic [7:0] t;
      int j;
      s = v;
      for (int i = 1; i < 9; i++) begin
         t = s[i];
         j = i - 1;
         while (j >= 0 && s[j] > t) begin
            s[j+1] = s[j];
            j--;
         end
         s[j+1] = t;
      end
      return s;
   endfunction

   // Presents one vector; the expectation is queued on the cycle it is accepted.
   task automatic send(input vec_t v, input logic push, input logic [7:0] e_med,
                       input logic [7:0] e_min, input logic [7:0] e_max, input logic chk_lat);
      exp_t e;
      logic done;
      done = 1'b0;
      x_flat = pack(v);
      in_valid = 1'b1;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) begin
               e.med = e_med; e.mn = e_min; e.mx = e_max; e.cyc = cyc; e.chk_lat = chk_lat;
               sb.push_back(e);
            end
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_model(input vec_t v, input logic chk_lat);
      vec_t s;
      s = model_sort(v);
      send(v, 1'b1, s[4], s[0], s[8], chk_lat);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || out_valid) && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (out_valid && !out_ready) begin
            stall_seen++;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("median", {24'd0, median}, {24'd0, e.med});
               check("min_val", {24'd0, min_val}, {24'd0, e.mn});
               check("max_val", {24'd0, max_val}, {24'd0, e.mx});
               check("out_count", {16'd0, out_count}, 32'(deliv));
               if (e.chk_lat) check("latency", 32'(cyc - e.cyc), 32'(N));
            end
            deliv++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vec_t r;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_median", {24'd0, median}, 32'd0);
      check("rst_min_max", {16'd0, min_val, max_val}, 32'd0);
      check("rst_out_count", {16'd0, out_count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      send(v, 1'b1, 8'd5, 8'd1, 8'd9, 1'b1);
      drain();
      check("count_after_first", {16'd0, out_count}, 32'd1);

      v = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      send(v, 1'b1, 8'd5, 8'd1, 8'd9, 1'b1);
      v = '{8'd19, 8'd18, 8'd17, 8'd16, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
      send(v, 1'b1, 8'd15, 8'd11, 8'd19, 1'b1);
      for (int i = 0; i < 9; i++) v[i] = 8'd255;
      send(v, 1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
      for (int i = 0; i < 9; i++) v[i] = 8'd0;
      send(v, 1'b1, 8'd0, 8'd0, 8'd0, 1'b1);
      v = '{8'd3, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd5, 8'd5};
      send(v, 1'b1, 8'd2, 8'd1, 8'd5, 1'b1);
      v = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
      send(v, 1'b1, 8'd0, 8'd0, 8'd255, 1'b1);
      drain();
      check("count_after_directed", {16'd0, out_count}, 32'd7);

      // Four vectors in flight, then reset: none of them may ever appear.
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 9; i++) v[i] = 8'(40 + k * 9 + i);
         send(v, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
      end
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_outputs", {8'd0, median, min_val, max_val}, 32'd0);
      check("midrst_out_count", {16'd0, out_count}, 32'd0);
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      deliv = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      v = '{8'd50, 8'd10, 8'd90, 8'd30, 8'd70, 8'd20, 8'd80, 8'd40, 8'd60};
      send(v, 1'b1, 8'd50, 8'd10, 8'd90, 1'b1);
      drain();
      check("count_after_reset", {16'd0, out_count}, 32'd1);

      // Twenty-vector stream with a three-cycle output stall in the middle.
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               for (int i = 0; i < 9; i++) r[i] = 8'((k * 37 + i * 101 + (i * i) * 13 + 7) % 256);
               send_model(r, 1'b0);
            end
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("stall_cycles", 32'(stall_seen), 32'd3);
      check("count_after_stream", {16'd0, out_count}, 32'd21);

      // N=3, WIDTH=16 instance: element 0 = 0xFFFF, 1 = 0x0001, 2 = 0x8000.
      @(negedge clk);
      x_flat3 = {16'h8000, 16'h0001, 16'hFFFF};
      in_valid3 = 1'b1;
      @(posedge clk);
      #1;
      in_valid3 = 1'b0;
      @(negedge clk);
      check("n3_valid_c1", {31'd0, out_valid3}, 32'd0);
      @(negedge clk);
      check("n3_valid_c2", {31'd0, out_valid3}, 32'd0);
      @(negedge clk);
      check("n3_valid_c3", {31'd0, out_valid3}, 32'd1);
      check("n3_median", {16'd0, median3}, 32'h8000);
      check("n3_min", {16'd0, min3}, 32'h0001);
      check("n3_max", {16'd0, max3}, 32'hFFFF);
      @(negedge clk);
      check("n3_count", {16'd0, out_count3}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
